// File: rtl/scaled_addsub_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | scaled_addsub_pipe : 3-stage add/sub for {scale, mant} scaled fixed point |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module scaled_addsub_pipe #(
  parameter int SCALE_W = 3,
  parameter int MANT_W  = 13,
  parameter int DW      = SCALE_W + MANT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sub,
  input  logic          in_cin,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic          out_ovf,
  output logic          out_inexact
);
  localparam int IW = MANT_W + (1 << SCALE_W);
  localparam int NK = 1 << SCALE_W;

  logic en;

  logic                 s1_valid_d, s1_valid_q, s1_sub_d, s1_sub_q, s1_cin_d, s1_cin_q;
  logic [SCALE_W-1:0]   s1_smax_d, s1_smax_q;
  logic signed [IW-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q;
  logic [SCALE_W-1:0]   sa, sb;

  logic                 s2_valid_d, s2_valid_q;
  logic [SCALE_W-1:0]   s2_smax_d, s2_smax_q;
  logic signed [IW:0]   s2_r_d, s2_r_q;
  logic signed [IW:0]   ext_a, ext_b, ext_c;

  logic                 s3_valid_d, s3_valid_q, s3_ovf_d, s3_ovf_q, s3_inexact_d, s3_inexact_q;
  logic [DW-1:0]        s3_res_d, s3_res_q;
  logic                 found;
  logic [SCALE_W-1:0]   k_sel;
  logic signed [IW:0]   trial, shr;
  logic [IW:0]          lost_mask;

  assign en        = !s3_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid_q;
  assign out_res   = s3_res_q;
  assign out_ovf   = s3_ovf_q;
  assign out_inexact = s3_inexact_q;

  // S1: align both mantissas to the larger scale
  always_comb begin
    sa         = in_a[DW-1:MANT_W];
    sb         = in_b[DW-1:MANT_W];
    s1_valid_d = in_valid;
    s1_sub_d   = in_sub;
    s1_cin_d   = in_cin;
    s1_smax_d  = (sa > sb) ? sa : sb;
    s1_a_d     = IW'($signed(in_a[MANT_W-1:0])) <<< (s1_smax_d - sa);
    s1_b_d     = IW'($signed(in_b[MANT_W-1:0])) <<< (s1_smax_d - sb);
  end

  // S2: one extra bit so the sum/difference never wraps
  always_comb begin
    ext_a      = {s1_a_q[IW-1], s1_a_q};
    ext_b      = {s1_b_q[IW-1], s1_b_q};
    ext_c      = {{IW{1'b0}}, s1_cin_q};
    s2_valid_d = s1_valid_q;
    s2_smax_d  = s1_smax_q;
    s2_r_d     = s1_sub_q ? (ext_a - ext_b - ext_c) : (ext_a + ext_b + ext_c);
  end

  // S3: smallest right shift (bounded by available scale) that fits the mantissa
  always_comb begin
    found = 1'b0;
    k_sel = '0;
    trial = s2_r_q;
    for (int k = 0; k < NK; k++) begin
      trial = s2_r_q >>> k;
      if (!found && (k <= int'(s2_smax_q)) &&
          ((&trial[IW:MANT_W-1]) || !(|trial[IW:MANT_W-1]))) begin
        found = 1'b1;
        k_sel = k[SCALE_W-1:0];
      end
    end
    shr        = s2_r_q >>> k_sel;
    lost_mask  = ~({(IW+1){1'b1}} << k_sel);
    s3_valid_d = s2_valid_q;
    if (found) begin
      s3_res_d     = {s2_smax_q - k_sel, shr[MANT_W-1:0]};
      s3_ovf_d     = 1'b0;
      s3_inexact_d = |(s2_r_q & lost_mask);
    end else begin
      s3_res_d     = {{SCALE_W{1'b0}},
                      s2_r_q[IW] ? {1'b1, {(MANT_W-1){1'b0}}} : {1'b0, {(MANT_W-1){1'b1}}}};
      s3_ovf_d     = 1'b1;
      s3_inexact_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sub_q     <= 1'b0;
      s1_cin_q     <= 1'b0;
      s1_smax_q    <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_smax_q    <= '0;
      s2_r_q       <= '0;
      s3_valid_q   <= 1'b0;
      s3_res_q     <= '0;
      s3_ovf_q     <= 1'b0;
      s3_inexact_q <= 1'b0;
    end else if (en) begin
      s1_valid_q   <= s1_valid_d;
      s1_sub_q     <= s1_sub_d;
      s1_cin_q     <= s1_cin_d;
      s1_smax_q    <= s1_smax_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_smax_q    <= s2_smax_d;
      s2_r_q       <= s2_r_d;
      s3_valid_q   <= s3_valid_d;
      s3_res_q     <= s3_res_d;
      s3_ovf_q     <= s3_ovf_d;
      s3_inexact_q <= s3_inexact_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scaled_addsub_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scaled_addsub_pipe : self-checking bench for scaled_addsub_pipe        |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_scaled_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        in_cin = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_ovf, out_inexact;
  logic [15:0] out_res;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];

  scaled_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_cin(in_cin), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_ovf(out_ovf), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  // Reference: exact real-valued arithmetic on mant*2^-scale, returned as {ovf, inexact, res}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    logic signed [12:0] ma, mb;
    int sa, sb, smax;
    longint ra, rb, r, v;
    ma = a[12:0];
    mb = b[12:0];
    sa = int'(a[15:13]);
    sb = int'(b[15:13]);
    smax = (sa > sb) ? sa : sb;
    ra = longint'(ma) * (longint'(1) << (smax - sa));
    rb = longint'(mb) * (longint'(1) << (smax - sb));
    r  = sub ? (ra - rb - longint'(cin)) : (ra + rb + longint'(cin));
    for (int k = 0; k <= smax; k++) begin
      v = r >>> k;
      if (v >= -4096 && v <= 4095)
        return {1'b0, (r != v * (longint'(1) << k)), 3'(smax - k), 13'(v)};
    end
    return {1'b1, 1'b1, 3'd0, (r < 0) ? 13'h1000 : 13'h0FFF};
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_res !== 16'h0 || out_ovf !== 1'b0 || out_inexact !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b res=%h ovf=%b inx=%b, want 0 0000 0 0",
               out_valid, out_res, out_ovf, out_inexact);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [10] = '{16'h4005, 16'h2FFF, 16'h0FFF, 16'h1000, 16'h2FFF,
                             16'h2FFF, 16'h0005, 16'hFFFF, 16'h6005, 16'h3FFD};
    logic [15:0] vb [10] = '{16'h0003, 16'h2FFF, 16'h0001, 16'h0001, 16'h2001,
                             16'h2002, 16'h0003, 16'h0FFF, 16'h6005, 16'h3000};
    logic        vs [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [17:0] ve [10] = '{18'h04011, 18'h00FFF, 18'h30FFF, 18'h31000, 18'h00800,
                             18'h10800, 18'h00001, 18'h10FFE, 18'h06000, 18'h117FE};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_a = va[i]; in_b = vb[i]; in_sub = vs[i]; in_cin = vc[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_latency: out_valid=%b two cycles after transfer, want 0", i, out_valid);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || {out_ovf, out_inexact, out_res} !== ve[i]) begin
        bad++;
        $display("FAIL dir%0d_result: got v=%b {ovf,inx,res}=%h, want v=1 %h",
                 i, out_valid, {out_ovf, out_inexact, out_res}, ve[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] oa [5], ob [5];
    logic        os [5];
    int idx = 0;
    int got = 0;
    logic [17:0] e;
    for (int i = 0; i < 5; i++) begin
      oa[i] = 16'($urandom()); ob[i] = 16'($urandom()); os[i] = 1'($urandom());
    end
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = (idx < 5);
      if (idx < 5) begin in_a = oa[idx]; in_b = ob[idx]; in_sub = os[idx]; in_cin = 1'b0; end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
        idx++;
      end
    end
    total++;
    if (idx !== 3 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept_count: got accepted=%0d in_ready=%b, want 3 and 0", idx, in_ready);
    end
    total++;
    if (out_valid !== 1'b1 || {out_ovf, out_inexact, out_res} !== exp_q[0]) begin
      bad++;
      $display("FAIL bp_held_output: got v=%b %h, want v=1 %h",
               out_valid, {out_ovf, out_inexact, out_res}, exp_q[0]);
    end
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 5);
      if (idx < 5) begin in_a = oa[idx]; in_b = ob[idx]; in_sub = os[idx]; in_cin = 1'b0; end
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bp_order: got unexpected %h, want none", {out_ovf, out_inexact, out_res});
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_inexact, out_res} !== e) begin
            bad++;
            $display("FAIL bp_order: result %0d got %h, want %h", got, {out_ovf, out_inexact, out_res}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
        idx++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (got !== 5 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL bp_drain: got %0d results, %0d left, want 5 and 0", got, exp_q.size());
    end
  endtask

  // pv/pr: percent chance of in_valid / out_ready each cycle
  task automatic test_stream(input int ncyc, input int pv, input int pr);
    logic        hold_v = 1'b0;
    logic [17:0] hold_d = '0;
    logic [17:0] e;
    exp_q.delete();
    for (int c = 0; c < ncyc + 20; c++) begin
      @(negedge clk);
      if (c < ncyc) begin
        in_valid  = (int'($urandom_range(99)) < pv);
        in_a      = 16'($urandom());
        in_b      = 16'($urandom());
        in_sub    = 1'($urandom());
        in_cin    = 1'($urandom());
        out_ready = (int'($urandom_range(99)) < pr);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (pr == 100) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_in_ready: cycle %0d got %b, want 1", c, in_ready);
        end
      end
      if (hold_v) begin
        total++;
        if (out_valid !== 1'b1 || {out_ovf, out_inexact, out_res} !== hold_d) begin
          bad++;
          $display("FAIL stall_stable: cycle %0d got v=%b %h, want v=1 %h",
                   c, out_valid, {out_ovf, out_inexact, out_res}, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_result: cycle %0d got unexpected %h, want none", c, {out_ovf, out_inexact, out_res});
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_inexact, out_res} !== e) begin
            bad++;
            $display("FAIL stream_result: cycle %0d got %h, want %h", c, {out_ovf, out_inexact, out_res}, e);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_ovf, out_inexact, out_res};
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL stream_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_flight();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1; in_a = 16'h4005; in_b = 16'h0003; in_sub = 1'b0; in_cin = 1'b0;
    @(negedge clk);
    in_a = 16'h2FFF; in_b = 16'h2001;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_flight_next: got out_valid=%b in_ready=%b, want 0 and 1", out_valid, in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_flight_stale: cycle %0d got out_valid=%b res=%h, want 0", c, out_valid, out_res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream(300, 75, 70);
    test_stream(40, 100, 100);
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
